// File: rtl/linked_list_sched.sv
// Push/pop scheduler for the shared-memory N-list linked list: at most one one-hot op per cycle.
// Optional per-list occupancy quota is enabled by defining LLS_QUOTA_EN.
module linked_list_sched #(
  parameter int NUM_LISTS  = 2,
  parameter int NUM_ELEMS  = 4,
  parameter int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
  parameter int CNT_WIDTH  = $clog2(NUM_ELEMS) + 1,
  parameter int QUOTA      = NUM_ELEMS / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LISTS-1:0]  push_req,
  output logic [NUM_LISTS-1:0]  push_gnt,
  input  logic                  deq_ready,
  output logic                  deq_valid,
  output logic [LIST_WIDTH-1:0] deq_list,
  input  logic                  ll_full,
  input  logic [NUM_LISTS-1:0]  ll_empty,
  output logic [NUM_LISTS-1:0]  ll_push,
  output logic [NUM_LISTS-1:0]  ll_pop
);

  logic [LIST_WIDTH-1:0] r_pushPtr;
  logic [LIST_WIDTH-1:0] r_popPtr;
  logic                  r_prio;

  logic [NUM_LISTS-1:0]  w_pushReq;
  logic                  w_pushFound;
  logic [LIST_WIDTH-1:0] w_pushIdx;
  logic                  w_popFound;
  logic [LIST_WIDTH-1:0] w_popIdx;
  logic                  w_pushElig;
  logic                  w_popElig;
  logic                  w_grantPush;
  logic                  w_grantPop;
  logic [LIST_WIDTH-1:0] w_pushNext;
  logic [LIST_WIDTH-1:0] w_popNext;

`ifdef LLS_QUOTA_EN
  logic [CNT_WIDTH-1:0] r_occ [NUM_LISTS];

  // Lists at quota are hidden from arbitration, so the pointer naturally skips them
  always_comb begin
    w_pushReq = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      w_pushReq[i] = push_req[i] && (r_occ[i] < CNT_WIDTH'(QUOTA));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LISTS; i++) r_occ[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        if (w_grantPush && (w_pushIdx == LIST_WIDTH'(i)))
          r_occ[i] <= r_occ[i] + CNT_WIDTH'(1);
        else if (w_grantPop && (w_popIdx == LIST_WIDTH'(i)))
          r_occ[i] <= r_occ[i] - CNT_WIDTH'(1);
      end
    end
  end
`else
  assign w_pushReq = push_req;
`endif

  // Round-robin scans starting at each pointer, wrapping modulo NUM_LISTS
  always_comb begin
    int idx;
    idx         = 0;
    w_pushFound = 1'b0;
    w_pushIdx   = '0;
    w_popFound  = 1'b0;
    w_popIdx    = '0;
    for (int j = 0; j < NUM_LISTS; j++) begin
      idx = (int'(r_pushPtr) + j) % NUM_LISTS;
      if (!w_pushFound && w_pushReq[idx]) begin
        w_pushFound = 1'b1;
        w_pushIdx   = LIST_WIDTH'(idx);
      end
      idx = (int'(r_popPtr) + j) % NUM_LISTS;
      if (!w_popFound && !ll_empty[idx]) begin
        w_popFound = 1'b1;
        w_popIdx   = LIST_WIDTH'(idx);
      end
    end
  end

  assign w_pushElig  = w_pushFound && !ll_full;
  assign w_popElig   = deq_ready && w_popFound;
  assign w_grantPush = !rst && w_pushElig && (!w_popElig || !r_prio);
  assign w_grantPop  = !rst && w_popElig && (!w_pushElig || r_prio);

  assign w_pushNext = (w_pushIdx == LIST_WIDTH'(NUM_LISTS - 1)) ? '0 : w_pushIdx + LIST_WIDTH'(1);
  assign w_popNext  = (w_popIdx == LIST_WIDTH'(NUM_LISTS - 1)) ? '0 : w_popIdx + LIST_WIDTH'(1);

  assign push_gnt  = w_grantPush ? (NUM_LISTS'(1) << w_pushIdx) : '0;
  assign ll_push   = push_gnt;
  assign ll_pop    = w_grantPop ? (NUM_LISTS'(1) << w_popIdx) : '0;
  assign deq_valid = w_grantPop;
  assign deq_list  = w_grantPop ? w_popIdx : '0;

  // Priority only flips when both sides were eligible in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pushPtr <= '0;
      r_popPtr  <= '0;
      r_prio    <= 1'b0;
    end else begin
      if (w_grantPush) r_pushPtr <= w_pushNext;
      if (w_grantPop)  r_popPtr  <= w_popNext;
      if (w_pushElig && w_popElig) r_prio <= ~r_prio;
    end
  end

endmodule
